async_fifo_wr_arbiter: RTL and testbench

Round-robin arbiter sharing the single write port of one async_fifo among NUM_REQ requesters in the write-clock domain. Grants are packet-locked: once granted, a requester owns the port until it presents its last beat or hits MAX_BURST beats. Backpressure from the FIFO `full` flag is propagated to the granted requester. Sits directly in front of async_fifo `wr_en`/`wr_data`/`full`.

---
 rtl/async_fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_arbiter
//
// Round-robin, packet-locked arbiter that shares the single write port of one
// async_fifo among NUM_REQ requesters in the write-clock domain. A granted
// requester keeps the port until it presents its last beat or until MAX_BURST
// beats have been accepted, whichever comes first. The FIFO full flag stalls
// the granted requester. Payload pass-through is combinational.
//
// Optional feature (macro ASYNC_FIFO_WR_ARB_TAG_EN):
//   defined   : fifo_wr_data = {grant_id, payload}, width DATA_WIDTH+IDW
//   undefined : fifo_wr_data = payload, width DATA_WIDTH
//
// Ports:
//   clk          write-domain clock (same as async_fifo wr_clk)
//   rst_n        synchronous active-low reset
//   req_valid    per-requester beat valid
//   req_data     per-requester payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     per-requester last beat of packet
//   req_ready    per-requester accept (beat moves when valid & ready)
//   fifo_wr_en   to async_fifo wr_en
//   fifo_wr_data to async_fifo wr_data
//   fifo_full    from async_fifo full
//   grant_id     index of current owner, meaningful while busy
//   busy         high while a grant is held
// -----------------------------------------------------------------------------
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
`ifdef ASYNC_FIFO_WR_ARB_TAG_EN
  output logic [DATA_WIDTH+IDW-1:0]     fifo_wr_data,
`else
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
`endif
  input  logic                          fifo_full,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] TOP_ID    = IDW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           accept;
  logic [DATA_WIDTH-1:0] payload;

  // First requester at or after ptr, scanning upward with wrap-around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && vld[IDW'(idx)]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
    return (id == TOP_ID) ? '0 : id + IDW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        // No beat moves in IDLE; the winner is registered and served next cycle.
        if (|req_valid) begin
          grant_d    = rr_pick(req_valid, rr_ptr_q);
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // Full blocks every ready so the FIFO never sees wr_en with full=1.
        if (!fifo_full) req_ready[grant_q] = 1'b1;
        accept = req_valid[grant_q] & ~fifo_full & rst_n;
        if (accept) begin
          if (req_last[grant_q] || (beat_cnt_q == LAST_BEAT)) begin
            state_d    = IDLE;
            rr_ptr_d   = rr_next(grant_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts any transfer in the same cycle.
    if (!rst_n) req_ready = '0;
  end

  always_comb begin
    payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDW'(i)) payload = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_en = accept;
`ifdef ASYNC_FIFO_WR_ARB_TAG_EN
  assign fifo_wr_data = {grant_q, payload};
`else
  assign fifo_wr_data = payload;
`endif
  assign grant_id = grant_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for async_fifo_wr_arbiter. Randomised requesters push each beat
// they generate into a per-requester expected queue; a negedge monitor keeps a
// transaction-level model of grant ownership and rotation, checks handshake
// outputs every cycle and pops/compares the queue of the owner on each write.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = $clog2(NUM_REQ);
`ifdef ASYNC_FIFO_WR_ARB_TAG_EN
  localparam int OW = DW + IDW;
`else
  localparam int OW = DW;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_wr_en;
  logic [OW-1:0]         fifo_wr_data;
  logic                  fifo_full;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  always #5 clk = ~clk;

  async_fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_full   (fifo_full),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {last, data} of every beat each requester has issued.
  logic [DW:0] exp_q [NUM_REQ][$];

  // Requester-side state
  logic          have    [NUM_REQ];
  int            pkt_left[NUM_REQ];
  logic [DW-1:0] cur_d   [NUM_REQ];
  logic          cur_l   [NUM_REQ];
  logic          acc     [NUM_REQ];
  logic          mon_en = 1'b0;

  // Reference model of ownership
  logic m_busy = 1'b0;
  int   m_gid  = 0;
  int   m_ptr  = 0;
  int   m_cnt  = 0;
  int   grants_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_wr;
    logic [DW:0]        beat;
    logic [OW-1:0]      exp_data;
    for (int i = 0; i < NUM_REQ; i++) acc[i] = req_valid[i] & req_ready[i];
    if (mon_en) begin
      exp_ready = '0;
      exp_wr    = 1'b0;
      if (rst_n && m_busy) begin
        if (!fifo_full) exp_ready[m_gid] = 1'b1;
        exp_wr = req_valid[m_gid] && !fifo_full;
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
      if (fifo_wr_en && fifo_full) chk("wr_while_full", 32'(1), 32'(0));
      if (exp_wr) begin
        if (exp_q[m_gid].size() == 0) begin
          chk("sb_underflow", 32'(m_gid), 32'hFFFF_FFFF);
        end else begin
          beat = exp_q[m_gid].pop_front();
`ifdef ASYNC_FIFO_WR_ARB_TAG_EN
          exp_data = {IDW'(m_gid), beat[DW-1:0]};
`else
          exp_data = beat[DW-1:0];
`endif
          chk("fifo_wr_data", 32'(fifo_wr_data), 32'(exp_data));
        end
      end
      // Advance the model with the inputs the next edge will sample.
      if (!rst_n) begin
        m_busy = 1'b0; m_ptr = 0; m_gid = 0; m_cnt = 0;
      end else if (!m_busy) begin
        if (|req_valid) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (req_valid[idx]) begin
              m_gid = idx;
              break;
            end
          end
          m_busy = 1'b1;
          m_cnt  = 0;
          grants_seen++;
        end
      end else if (exp_wr) begin
        m_cnt++;
        if (req_last[m_gid] || m_cnt == MAX_BURST) begin
          m_busy = 1'b0;
          m_ptr  = (m_gid + 1) % NUM_REQ;
          m_cnt  = 0;
        end
      end
    end
  end

  // One cycle of requester behaviour, called just after each rising edge.
  task automatic step(input int gen_pct, input int drop_pct, input int maxlen);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) have[i] = 1'b0;
      if (!have[i] && (pkt_left[i] > 0 || int'($urandom_range(99)) < gen_pct)) begin
        if (pkt_left[i] == 0) pkt_left[i] = int'($urandom_range(maxlen, 1));
        cur_d[i] = DW'($urandom);
        cur_l[i] = (pkt_left[i] == 1);
        pkt_left[i]--;
        exp_q[i].push_back({cur_l[i], cur_d[i]});
        have[i] = 1'b1;
      end
      req_valid[i]         = have[i] && (int'($urandom_range(99)) >= drop_pct);
      req_data[i*DW +: DW] = cur_d[i];
      req_last[i]          = cur_l[i];
    end
  endtask

  initial begin
    int full_run;
    int rst_hold;
    logic rst_pending;
    int remaining;
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      have[i] = 1'b0; pkt_left[i] = 0; cur_d[i] = '0; cur_l[i] = 1'b0; acc[i] = 1'b0;
    end

    // Reset held with every requester valid
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (5) begin
      step(100, 0, 1);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    // Continuous single-beat packets from everyone: strict rotation
    repeat (40) begin
      step(100, 0, 1);
      @(posedge clk); #1;
    end

    // Random traffic with full stalls, valid gaps and one mid-burst reset
    full_run    = 0;
    rst_hold    = 0;
    rst_pending = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      if (full_run > 0) begin
        fifo_full = 1'b1;
        full_run--;
      end else if ($urandom_range(99) < 3) begin
        fifo_full = 1'b1;
        full_run  = 5;
      end else begin
        fifo_full = ($urandom_range(99) < 10);
      end
      if (j == 1500) rst_pending = 1'b1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if (rst_pending && busy) begin
        rst_n       = 1'b0;
        rst_hold    = 2;
        rst_pending = 1'b0;
      end
      step(40, 15, 10);
      @(posedge clk); #1;
    end
    rst_n     = 1'b1;
    fifo_full = 1'b0;

    // Drain: finish open packets, no new ones
    n = 0;
    remaining = 1;
    while (remaining != 0 && n < 3000) begin
      step(0, 0, 10);
      @(posedge clk); #1;
      remaining = 0;
      for (int i = 0; i < NUM_REQ; i++) remaining += exp_q[i].size();
      n++;
    end
    chk("drain_remaining", 32'(remaining), 32'(0));
    chk("grants_nonzero", 32'(grants_seen > 100), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
